meas_snapshot: RTL and testbench

- Sits between the period/duty counter stages and the SPI shifter.
- Captures the four 32-bit counter results into a shadow frame after each measured-signal rising edge. The capture is delayed until the counters have settled.
- Freezes the frame while an SPI transaction is active (cs low), so the MCU always reads one coherent frame.
- Flags loss of input (stale) and numbers each frame with a sequence count.

---
 rtl/meas_snapshot_pkg.sv | 32 +++
 rtl/meas_snapshot_snap_sync.sv | 29 ++
 rtl/meas_snapshot.sv | 191 +++++++++++++++++++
 tb/tb_meas_snapshot.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_snapshot_pkg.sv
// Shared types and constants for the measurement snapshot block.
// Holds the FSM encoding, frame layout offsets and the CRC-8 bit step.
package meas_snapshot_pkg;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned FRAME_W = 128;
    localparam int unsigned SEQ_W   = 4;
    localparam int unsigned CRC_W   = 8;

    localparam int unsigned H_T_LSB      = 0;
    localparam int unsigned PER_T_LSB    = 32;
    localparam int unsigned PER_DUTY_LSB = 64;
    localparam int unsigned DUTY_LSB     = 96;

    localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_CRC
    } state_e;

    // One MSB-first CRC-8 shift with data bit b.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = c[CRC_W-1] ^ b;
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC8_POLY : CRC_W'(0));
    endfunction

endpackage

// File: rtl/meas_snapshot_snap_sync.sv
// Multi-stage synchroniser for an asynchronous level with a rising-edge strobe.
// The strobe is combinational from the last two flops.
module snap_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_c_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign q_o      = sync_q[STAGES-1];
    assign rise_c_o = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/meas_snapshot.sv
// Captures the four counter results into a coherent SPI-readable frame after
// each measured edge. Optional serial CRC-8 of the frame under SNAP_CRC_EN.
module meas_snapshot
    import meas_snapshot_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sig,
    input  logic               cs,
    input  logic [CNT_W-1:0]   counter_h_T,
    input  logic [CNT_W-1:0]   counter_per_T,
    input  logic [CNT_W-1:0]   counter_per_duty,
    input  logic [CNT_W-1:0]   counter_duty,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    output logic [SEQ_W-1:0]   seq,
    output logic               stale,
    output logic [CRC_W-1:0]   crc
);

    localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

    logic sig_rise_c, sig_lvl_unused;
    logic cs_s, cs_rise_unused;
    logic busy_c;

    snap_sync #(.STAGES(SYNC_STAGES)) u_sig_sync (
        .clk(clk), .rst(reset), .d_i(sig), .q_o(sig_lvl_unused), .rise_c_o(sig_rise_c)
    );

    snap_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .rst(reset), .d_i(cs), .q_o(cs_s), .rise_c_o(cs_rise_unused)
    );

    assign busy_c = ~cs_s;

    state_e               state_q, state_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 tmo_done_q, tmo_done_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic                 fv_q, fv_d;
    logic                 stale_q, stale_d;
`ifdef SNAP_CRC_EN
    logic [6:0]           bit_q, bit_d;
    logic [CRC_W-1:0]     calc_q, calc_d;
    logic [CRC_W-1:0]     crc_q, crc_d;
    logic                 pend_q, pend_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            tmo_q      <= '0;
            tmo_done_q <= 1'b0;
            frame_q    <= '0;
            seq_q      <= '0;
            fv_q       <= 1'b0;
            stale_q    <= 1'b0;
`ifdef SNAP_CRC_EN
            bit_q      <= '0;
            calc_q     <= '0;
            crc_q      <= '0;
            pend_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            tmo_done_q <= tmo_done_d;
            frame_q    <= frame_d;
            seq_q      <= seq_d;
            fv_q       <= fv_d;
            stale_q    <= stale_d;
`ifdef SNAP_CRC_EN
            bit_q      <= bit_d;
            calc_q     <= calc_d;
            crc_q      <= crc_d;
            pend_q     <= pend_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        tmo_d      = tmo_q;
        tmo_done_d = tmo_done_q;
        frame_d    = frame_q;
        seq_d      = seq_q;
        fv_d       = fv_q;
        stale_d    = stale_q;
`ifdef SNAP_CRC_EN
        bit_d      = bit_q;
        calc_d     = calc_q;
        crc_d      = crc_q;
        pend_d     = pend_q;

        // A result finished during an SPI read is published once cs releases.
        if (pend_q && !busy_c) begin
            crc_d  = calc_q;
            pend_d = 1'b0;
        end
`endif

        if (sig_rise_c) begin
            tmo_d      = '0;
            tmo_done_d = 1'b0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (sig_rise_c) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_W'(SETTLE_CYC - 1);
                end else if (!busy_c && tmo_q == TMO_MAX && !tmo_done_q) begin
                    frame_d    = '0;
                    stale_d    = 1'b1;
                    tmo_done_d = 1'b1;
`ifdef SNAP_CRC_EN
                    crc_d      = '0;
                    pend_d     = 1'b0;
`endif
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = busy_c ? ST_WAIT : ST_CAPTURE;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            ST_WAIT: begin
                if (!busy_c) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                frame_d = {counter_duty, counter_per_duty, counter_per_T, counter_h_T};
                seq_d   = seq_q + SEQ_W'(1);
                fv_d    = 1'b1;
                stale_d = 1'b0;
`ifdef SNAP_CRC_EN
                state_d = ST_CRC;
                bit_d   = '0;
                calc_d  = '0;
                pend_d  = 1'b0;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef SNAP_CRC_EN
            ST_CRC: begin
                // Bit 127 first: ~bit_q walks the index downward from 127.
                calc_d = crc8_step(calc_q, frame_q[~bit_q]);
                bit_d  = bit_q + 7'd1;
                if (bit_q == 7'd127) begin
                    state_d = ST_IDLE;
                    if (busy_c) begin
                        pend_d = 1'b1;
                    end else begin
                        crc_d = calc_d;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign frame       = frame_q;
    assign frame_valid = fv_q;
    assign seq         = seq_q;
    assign stale       = stale_q;
`ifdef SNAP_CRC_EN
    assign crc         = crc_q;
`else
    assign crc         = '0;
`endif

endmodule

// File: tb/tb_meas_snapshot.sv
// Scoreboard bench for meas_snapshot: stimulus queues expected frames, a
// negedge monitor pops and checks each time frame/seq/stale update.
module tb_meas_snapshot;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned SETTLE = 4;
`ifdef SNAP_CRC_EN
    localparam int unsigned TMO = 400;
    localparam int unsigned GAP = 150;
`else
    localparam int unsigned TMO = 100;
    localparam int unsigned GAP = 25;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         sig;
    logic         cs;
    logic [31:0]  c_h_t, c_per_t, c_per_duty, c_duty;
    logic [127:0] frame;
    logic         frame_valid;
    logic [3:0]   seq;
    logic         stale;
    logic [7:0]   crc;

    meas_snapshot #(
        .SYNC_STAGES(SYNC), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .sig(sig), .cs(cs),
        .counter_h_T(c_h_t), .counter_per_T(c_per_t),
        .counter_per_duty(c_per_duty), .counter_duty(c_duty),
        .frame(frame), .frame_valid(frame_valid), .seq(seq), .stale(stale), .crc(crc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] frame;
        logic [3:0]   seq;
        logic         stale;
        logic         fv;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [127:0] f, input logic [3:0] s, input logic st, input logic v);
        exp_t e;
        e.frame = f; e.seq = s; e.stale = st; e.fv = v;
        return e;
    endfunction

    // Byte-at-a-time CRC-8/0x07 reference, most significant byte first.
    function automatic logic [7:0] crc8_ref(input logic [127:0] f);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            c = c ^ f[i*8 +: 8];
            for (int k = 0; k < 8; k++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: any update of frame/seq/stale must match the head of the scoreboard.
    logic [127:0] p_frame;
    logic [3:0]   p_seq;
    logic         p_stale;
    int           crc_wait;
    logic [7:0]   crc_exp;
    exp_t         m_e;

    always @(negedge clk) begin
        if (reset) begin
            p_frame  = '0;
            p_seq    = '0;
            p_stale  = 1'b0;
            crc_wait = 0;
        end else begin
            if (frame !== p_frame || seq !== p_seq || stale !== p_stale) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update frame=%h seq=%0d stale=%b required=no update",
                             frame, seq, stale);
                end else begin
                    m_e = sb_q.pop_front();
                    chk("mon_frame", frame, m_e.frame);
                    chk("mon_seq", 128'(seq), 128'(m_e.seq));
                    chk("mon_stale", 128'(stale), 128'(m_e.stale));
                    chk("mon_frame_valid", 128'(frame_valid), 128'(m_e.fv));
`ifdef SNAP_CRC_EN
                    if (m_e.stale) begin
                        chk("mon_crc_stale", 128'(crc), 128'(0));
                        crc_wait = 0;
                    end else begin
                        crc_exp  = crc8_ref(m_e.frame);
                        crc_wait = 135;
                    end
`else
                    chk("mon_crc_zero", 128'(crc), 128'(0));
`endif
                end
            end
`ifdef SNAP_CRC_EN
            if (crc_wait > 0) begin
                crc_wait--;
                if (crc_wait == 0) chk("mon_crc", 128'(crc), 128'(crc_exp));
            end
`endif
            p_frame = frame;
            p_seq   = seq;
            p_stale = stale;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cnt(input logic [31:0] h, input logic [31:0] pt,
                           input logic [31:0] pd, input logic [31:0] d);
        c_h_t = h; c_per_t = pt; c_per_duty = pd; c_duty = d;
    endtask

    task automatic pulse_sig();
        @(negedge clk);
        sig = 1'b1;
        cycles(6);
        sig = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drain", 128'(sb_q.size()), 128'(0));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_frame"}, frame, 128'(0));
        chk({tag, "_frame_valid"}, 128'(frame_valid), 128'(0));
        chk({tag, "_seq"}, 128'(seq), 128'(0));
        chk({tag, "_stale"}, 128'(stale), 128'(0));
        chk({tag, "_crc"}, 128'(crc), 128'(0));
    endtask

    logic [127:0] f1, f2;
    int           lat;

    initial begin
        #10000000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sig = 1'b0; cs = 1'b1;
        set_cnt(32'h0, 32'h0, 32'h0, 32'h0);
        cycles(3);
        check_zero("reset");
        reset = 1'b0;

        // Basic capture and its latency from the first sampling edge.
        set_cnt(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        f1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        sb_q.push_back(mk(f1, 4'd1, 1'b0, 1'b1));
        @(negedge clk);
        sig = 1'b1;
        lat = 0;
        while (frame == 128'(0) && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("capture_latency", 128'(lat), 128'(SYNC + SETTLE + 2));
        @(negedge clk);
        sig = 1'b0;
        wait_drain();
        cycles(GAP);

        // cs low across the settle window: frozen, then capture of late value.
        cs = 1'b0;
        c_h_t = 32'h10;
        f2 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h00000020};
        sb_q.push_back(mk(f2, 4'd2, 1'b0, 1'b1));
        pulse_sig();
        cycles(SYNC + SETTLE + 4);
        chk("busy_frame_frozen", frame, f1);
        chk("busy_seq_frozen", 128'(seq), 128'(1));
        c_h_t = 32'h20;
        cycles(3);
        cs = 1'b1;
        wait_drain();
        cycles(GAP);

        // Reset during SETTLE: immediate clear, no capture afterwards.
        set_cnt(32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555);
        @(negedge clk);
        sig = 1'b1;
        cycles(SYNC + 2);
        #2 reset = 1'b1;
        #1 check_zero("reset_settle");
        sig = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(SETTLE + 10);
        chk("post_reset_no_capture_fv", 128'(frame_valid), 128'(0));
        chk("post_reset_no_capture_seq", 128'(seq), 128'(0));

        // 17 captures: sequence number wraps 15 -> 0 -> 1.
        for (int i = 0; i < 17; i++) begin
            set_cnt(32'h10000000 + 32'(i), 32'h20000000 + 32'(i),
                    32'h30000000 + 32'(i), 32'h40000000 + 32'(i));
            sb_q.push_back(mk({32'h40000000 + 32'(i), 32'h30000000 + 32'(i),
                               32'h20000000 + 32'(i), 32'h10000000 + 32'(i)},
                              4'(i + 1), 1'b0, 1'b1));
            pulse_sig();
            cycles(GAP - 6);
        end
        wait_drain();

        // Timeout: stale frame after TMO idle cycles, cleared by the next capture.
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        set_cnt(32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004);
        sb_q.push_back(mk({32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001},
                          4'd1, 1'b0, 1'b1));
        sb_q.push_back(mk(128'(0), 4'd1, 1'b1, 1'b1));
        pulse_sig();
        cycles(TMO + 30);
        wait_drain();
        set_cnt(32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004);
        sb_q.push_back(mk({32'hB0000004, 32'hB0000003, 32'hB0000002, 32'hB0000001},
                          4'd2, 1'b0, 1'b1));
        pulse_sig();
        wait_drain();
        cycles(5);

`ifdef SNAP_CRC_EN
        // All-ones frame CRC, then reset in the middle of a CRC run.
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        set_cnt(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        sb_q.push_back(mk({128{1'b1}}, 4'd1, 1'b0, 1'b1));
        pulse_sig();
        cycles(150);
        chk("crc_all_ones", 128'(crc), 128'(crc8_ref({128{1'b1}})));
        set_cnt(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978);
        sb_q.push_back(mk({32'h4B5A6978, 32'h0F1E2D3C, 32'h9ABCDEF0, 32'h12345678},
                          4'd2, 1'b0, 1'b1));
        pulse_sig();
        cycles(SYNC + SETTLE + 60);
        #2 reset = 1'b1;
        #1 check_zero("reset_crc");
        cycles(2);
        reset = 1'b0;
        cycles(150);
        chk("post_crc_reset_crc", 128'(crc), 128'(0));
        chk("post_crc_reset_seq", 128'(seq), 128'(0));
        wait_drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
